// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Circular-buffer FIFO placed in front of the UART transmitter. The host side
// pushes bytes with wr/w_data. The transmitter derives tx_start from ~empty and
// pops with its tx_done_tick on rd.
//
// Default build (pop-to-register): a successful pop loads the head word into an
// output holding register. r_data then keeps that word until the next
// successful pop, so the transmitter may latch it any time after its pulse.
//
// Build option UART_TX_FIFO_FWFT_EN (first-word-fall-through): r_data shows
// the head word combinationally while the FIFO is not empty, and 0 when it is
// empty. In this build, rd only advances the read pointer.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous active-low reset (0 = reset)
//   wr         write strobe; one word per cycle while high
//   w_data     write data [B-1:0]
//   rd         read/pop strobe
//   r_data     read data [B-1:0]
//   empty      registered; no words stored
//   full       registered; 2**W words stored
//   count      registered; stored word count [W:0], 0..2**W
//   overflow   sticky; a write was attempted while full
//   underflow  sticky; a read was attempted while empty
//   clr_err    synchronous clear of overflow/underflow (an error in the same
//              cycle wins)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
);

    localparam int DEPTH = 2 ** W;
    localparam logic [W:0] FULL_COUNT = (W+1)'(DEPTH);

    logic [B-1:0] mem_r [DEPTH];
    logic [W-1:0] w_ptr_r;
    logic [W-1:0] r_ptr_r;
    logic [W:0]   count_r;
    logic         empty_r;
    logic         full_r;
    logic         overflow_r;
    logic         underflow_r;

    logic         do_write_s;
    logic         do_read_s;
    logic         ovf_set_s;
    logic         udf_set_s;
    logic [W:0]   count_next_s;
    logic         overflow_next_s;
    logic         underflow_next_s;

    // Decode the {wr,rd} request against the registered flags into actions.
    always_comb begin
        do_write_s = 1'b0;
        do_read_s  = 1'b0;
        ovf_set_s  = 1'b0;
        udf_set_s  = 1'b0;
        case ({wr, rd})
            2'b00: begin
                do_write_s = 1'b0;
            end
            2'b10: begin
                if (full_r) begin
                    ovf_set_s = 1'b1;
                end else begin
                    do_write_s = 1'b1;
                end
            end
            2'b01: begin
                if (empty_r) begin
                    udf_set_s = 1'b1;
                end else begin
                    do_read_s = 1'b1;
                end
            end
            2'b11: begin
                // When the FIFO is empty there is nothing to pop, and the new
                // word is not bypassed. When it is full, the pop frees the slot
                // that the write refills, so count stays at the maximum.
                if (empty_r) begin
                    do_write_s = 1'b1;
                    udf_set_s  = 1'b1;
                end else begin
                    do_write_s = 1'b1;
                    do_read_s  = 1'b1;
                end
            end
            default: begin
                do_write_s = 1'b0;
            end
        endcase
    end

    // Compute the next count and the next sticky-error values.
    always_comb begin
        count_next_s = count_r + {{W{1'b0}}, do_write_s} - {{W{1'b0}}, do_read_s};
        if (ovf_set_s) begin
            overflow_next_s = 1'b1;
        end else if (clr_err) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
        if (udf_set_s) begin
            underflow_next_s = 1'b1;
        end else if (clr_err) begin
            underflow_next_s = 1'b0;
        end else begin
            underflow_next_s = underflow_r;
        end
    end

    // Pointers, count, flags and sticky errors. Flags come from the next count,
    // so they are valid in the cycle after the edge that caused them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_r     <= {W{1'b0}};
            r_ptr_r     <= {W{1'b0}};
            count_r     <= {(W+1){1'b0}};
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (do_write_s) begin
                w_ptr_r <= w_ptr_r + {{(W-1){1'b0}}, 1'b1};
            end
            if (do_read_s) begin
                r_ptr_r <= r_ptr_r + {{(W-1){1'b0}}, 1'b1};
            end
            count_r     <= count_next_s;
            empty_r     <= (count_next_s == {(W+1){1'b0}});
            full_r      <= (count_next_s == FULL_COUNT);
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    // Storage array. It has no reset, because words left over after a reset are
    // unreachable once the pointers return to zero.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[w_ptr_r] <= w_data;
        end
    end

`ifdef UART_TX_FIFO_FWFT_EN
    // The head word falls through to the output while data is present.
    always_comb begin
        if (empty_r) begin
            r_data = {B{1'b0}};
        end else begin
            r_data = mem_r[r_ptr_r];
        end
    end
`else
    logic [B-1:0] r_data_r;

    // The output holding register changes only on a successful pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_r <= {B{1'b0}};
        end else if (do_read_s) begin
            r_data_r <= mem_r[r_ptr_r];
        end
    end

    assign r_data = r_data_r;
`endif

    assign empty     = empty_r;
    assign full      = full_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_fifo. The reference model holds the FIFO contents in a
// queue and applies the FIFO rules to each cycle's request. After each edge,
// every DUT output is compared with the model.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int B     = 8;
    localparam int W     = 4;
    localparam int DEPTH = 16;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         wr      = 1'b0;
    logic         rd      = 1'b0;
    logic         clr_err = 1'b0;
    logic [B-1:0] w_data  = 8'h00;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] rdata_m = 8'h00;
    bit         ovf_m   = 1'b0;
    bit         udf_m   = 1'b0;

    uart_tx_fifo #(.B(B), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .w_data    (w_data),
        .rd        (rd),
        .r_data    (r_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rdata_m = 8'h00;
        ovf_m   = 1'b0;
        udf_m   = 1'b0;
    endtask

    // Apply one cycle of FIFO rules to the queue model.
    task automatic model_step(input bit w, input bit r, input logic [7:0] d, input bit c);
        bit was_full;
        bit was_empty;
        bit os;
        bit us;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        os = 1'b0;
        us = 1'b0;
        if (w && !r) begin
            if (was_full) os = 1'b1;
            else q.push_back(d);
        end else if (r && !w) begin
            if (was_empty) us = 1'b1;
            else rdata_m = q.pop_front();
        end else if (r && w) begin
            if (was_empty) begin
                q.push_back(d);
                us = 1'b1;
            end else begin
                rdata_m = q.pop_front();
                q.push_back(d);
            end
        end
        ovf_m = os ? 1'b1 : (c ? 1'b0 : ovf_m);
        udf_m = us ? 1'b1 : (c ? 1'b0 : udf_m);
    endtask

    function automatic logic [7:0] exp_rdata();
`ifdef UART_TX_FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : 8'h00;
`else
        return rdata_m;
`endif
    endfunction

    task automatic check_all();
        check_val("count", 32'(count), 32'(q.size()));
        check_val("empty", 32'(empty), 32'(q.size() == 0));
        check_val("full", 32'(full), 32'(q.size() == DEPTH));
        check_val("r_data", 32'(r_data), 32'(exp_rdata()));
        check_val("overflow", 32'(overflow), 32'(ovf_m));
        check_val("underflow", 32'(underflow), 32'(udf_m));
    endtask

    // Drive one request just after an edge, let the next edge take it, then
    // compare the outputs 1 time unit after that edge.
    task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
        wr      = w;
        rd      = r;
        w_data  = d;
        clr_err = c;
        @(posedge clk);
        model_step(w, r, d, c);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        check_all();
    endtask

    initial begin
        logic [7:0] last;
        int pw;
        int pr;

        // Power-on reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Single word in, single word out, output holds afterwards
        step(1'b1, 1'b0, 8'h55, 1'b0);
        check_val("one_count", 32'(count), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef UART_TX_FIFO_FWFT_EN
        check_val("one_pop", 32'(r_data), 32'h55);
`endif
        repeat (20) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill, overflow, then drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        check_val("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        check_val("ovf_set", 32'(overflow), 32'd1);
        check_val("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Wrap-around of the pointers
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Simultaneous write and pop while full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        check_val("full_wr_rd_count", 32'(count), 32'd16);
        check_val("full_wr_rd_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
`ifdef UART_TX_FIFO_FWFT_EN
        last = r_data;
        step(1'b0, 1'b1, 8'h00, 1'b0);
`else
        step(1'b0, 1'b1, 8'h00, 1'b0);
        last = r_data;
`endif
        check_val("last_out", 32'(last), 32'h77);

        // Underflow, and clr_err colliding with a new error
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("udf_set", 32'(underflow), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check_val("udf_err_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("udf_clr", 32'(underflow), 32'd0);

        // Write and pop together while empty: write only, underflow set
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);

        // Asynchronous reset between edges with five words stored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        wr = 1'b1;
        rd = 1'b1;
        w_data = 8'h99;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check_all();
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic, in phases with changing write/read bias
        for (int ph = 0; ph < 12; ph++) begin
            pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            pr = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 80 : 50);
            for (int k = 0; k < 200; k++) begin
                step(($urandom % 100) < pw, ($urandom % 100) < pr,
                     8'($urandom), ($urandom % 20) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Circular-buffer FIFO that sits directly upstream of the UART transmitter and buffers bytes from the host/ALU side until the serial line can accept them. Transmitter drives tx_start from ~empty, and its tx_done_tick pulse drives rd here. Default is pop-to-register: rd moves the head word into an output holding register. The transmitter can therefore latch r_data any number of cycles after its read pulse.

Parameters:
B, 8, data word width in bits
W, 4, address width; depth = 2**W entries (16)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
wr  input  1  write strobe, one word per cycle while high
w_data  input  B  write data, sampled when wr=1
rd  input  1  read/pop strobe (from transmitter tx_done_tick)
r_data  output  B  read data (see Behaviour / Optional Feature)
empty  output  1  no words stored
full  output  1  2**W words stored
count  output  W+1  number of stored words, 0..2**W
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset=0, async assert, sync release): w_ptr=0, r_ptr=0, count=0, empty=1, full=0, r_data=0, overflow=0, underflow=0. Memory contents are not reset.
- Storage: 2**W x B register array; w_ptr and r_ptr are W-bit and wrap from 2**W-1 to 0 naturally.
- Flags are registered and derived from next-state count. empty=(count==0); full=(count==2**W). Both are valid in the cycle after the causing edge. No combinational path from wr/rd to any flag.
- Control cases, per cycle, keyed on {wr,rd}:
  - 00: hold.
  - 10, not full: mem[w_ptr]<=w_data; w_ptr+1; count+1.
  - 10, full: write dropped; overflow<=1; pointers and count unchanged.
  - 01, not empty: r_data<=mem[r_ptr]; r_ptr+1; count-1.
  - 01, empty: no pop; r_data holds; underflow<=1.
  - 11, neither full nor empty: write and pop both occur; count unchanged.
  - 11, full: pop, then write into freed slot; count stays 2**W; no overflow.
  - 11, empty: write only; count=1; underflow<=1. No bypass: r_data unchanged.
- Pop-to-register: r_data changes only on a successful pop. It holds that word until the next successful pop, independent of further writes.
- Latency: a word written at edge N is visible as empty=0 after edge N. The earliest pop is at edge N+1, with r_data valid after edge N+1.
- clr_err=1 clears both sticky flags at the next edge. If an error occurs in the same cycle, the error wins (flag=1).
- Reset mid-operation discards all stored words immediately; any in-progress wr/rd in that cycle is ignored.

Optional Feature:
Macro UART_TX_FIFO_FWFT_EN.
- Defined: first-word-fall-through.
  - r_data = mem[r_ptr] combinationally whenever empty=0, and r_data=0 when empty.
  - rd only advances r_ptr.
  - Case 11 when empty: the word is written and appears on r_data after the edge.
  - All flag and count behaviour is unchanged.
- Undefined: pop-to-register behaviour as above, which is the build used with the current transmitter.

Test Plan:
- Reset, then write 0x55 with one wr pulse -> empty=0, count=1. Next-cycle rd -> r_data=0x55, empty=1, count=0; r_data still 0x55 20 cycles later.
- Write 0x00..0x0F (16 words) -> full=1, count=16. Write 0xAA -> overflow=1, count=16. Pop 16 times -> r_data sequence 0x00..0x0F, then empty=1.
- Wrap-around: push 10 and pop 10 words, then push 12 (0x20..0x2B) and pop 12 -> output order exact, count back to 0.
- Fill to 16, then wr=rd=1 with w_data=0x77 for one cycle -> r_data=0x00, count=16, overflow=0. After draining, 0x77 is last out.
- rd while empty -> underflow=1, r_data unchanged. clr_err together with a new empty rd -> underflow stays 1. clr_err alone -> underflow=0.
- Drive reset=0 asynchronously between edges while count=5 -> empty=1, count=0, r_data=0 immediately, without waiting for a clk edge.
